// File: rtl/lfsr_pkg.sv
// Shared definitions for the lfsr_gen block: default maximal-length tap masks,
// the per-edge action encoding and the pure Fibonacci step function.
package lfsr_pkg;

    localparam int unsigned LFSR_MAX_WIDTH = 32;

    // Default maximal-length feedback masks (bit i set = state[i] feeds the XOR).
    localparam logic [3:0]  TAPS_4  = 4'hC;
    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [31:0] TAPS_32 = 32'h80200003;

    // What the register bank does on the next rising edge.
    typedef enum logic [2:0] {
        ACT_HOLD    = 3'd0,
        ACT_RESET   = 3'd1,
        ACT_LOAD    = 3'd2,
        ACT_REJECT  = 3'd3,
        ACT_STEP    = 3'd4,
        ACT_WRAP    = 3'd5,
        ACT_RECOVER = 3'd6
    } lfsr_act_e;

    // One Fibonacci step on a zero-extended state; callers truncate to their width.
    // Tap bits above the real width are zero, so upper state bits never reach fb.
    function automatic logic [LFSR_MAX_WIDTH-1:0] lfsr_step(
        input logic [LFSR_MAX_WIDTH-1:0] state,
        input logic [LFSR_MAX_WIDTH-1:0] taps
    );
        logic fb;
        fb = ^(state & taps);
        return {state[LFSR_MAX_WIDTH-2:0], fb};
    endfunction

endpackage

// File: rtl/lfsr_gen_fb.sv
// Combinational feedback and next-state logic for lfsr_gen, plus the two
// comparisons the control path needs (zero state, step landing on the seed).
module lfsr_fb
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8
) (
    input  logic [WIDTH-1:0] state,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] next_state,
    output logic             state_zero,
    output logic             next_is_seed
);

    assign next_state   = WIDTH'(lfsr_step(LFSR_MAX_WIDTH'(state), LFSR_MAX_WIDTH'(TAPS)));
    assign state_zero   = (state == '0);
    assign next_is_seed = (next_state == seed);

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with runtime seed load, zero-state protection,
// a step counter and a wrap pulse at the end of each full period.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             sync_rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt_out,
    output logic [WIDTH-1:0] step_cnt,
    output logic             wrap,
    output logic             lock_err
);

    if (WIDTH < 3 || WIDTH > LFSR_MAX_WIDTH) begin : g_bad_width
        $error("lfsr_gen: WIDTH must lie in 3..32");
    end
    if (TAPS[WIDTH-1] != 1'b1) begin : g_bad_taps
        $error("lfsr_gen: TAPS must have bit WIDTH-1 set");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("lfsr_gen: SEED must be non-zero");
    end

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] seed_reg;
    logic [WIDTH-1:0] next_state;
    logic             state_zero;
    logic             next_is_seed;
    lfsr_act_e        act;

    lfsr_fb #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_fb (
        .state        (state),
        .seed         (seed_reg),
        .next_state   (next_state),
        .state_zero   (state_zero),
        .next_is_seed (next_is_seed)
    );

    // Priority: reset, then load (zero loads are rejected), then enabled step.
    always_comb begin
        // NOTE: default first so every path assigns act and no latch is inferred.
        act = ACT_HOLD;
        if (sync_rst) begin
            act = ACT_RESET;
        end else if (load) begin
            act = (load_val != '0) ? ACT_LOAD : ACT_REJECT;
        end else if (en) begin
            if (state_zero) begin
                act = ACT_RECOVER;
            end else if (next_is_seed) begin
                act = ACT_WRAP;
            end else begin
                act = ACT_STEP;
            end
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        wrap     <= 1'b0;
        lock_err <= 1'b0;
        unique case (act)
            ACT_RESET: begin
                state    <= SEED;
                seed_reg <= SEED;
                step_cnt <= '0;
            end
            ACT_LOAD: begin
                state    <= load_val;
                seed_reg <= load_val;
                step_cnt <= '0;
            end
            ACT_REJECT, ACT_RECOVER: begin
                state    <= SEED;
                seed_reg <= SEED;
                step_cnt <= '0;
                lock_err <= 1'b1;
            end
            ACT_WRAP: begin
                state    <= next_state;
                step_cnt <= '0;
                wrap     <= 1'b1;
            end
            ACT_STEP: begin
                state    <= next_state;
                step_cnt <= step_cnt + WIDTH'(1);
            end
            default: begin
                // ACT_HOLD: state, seed and counter keep their values.
            end
        endcase
    end

    assign cnt_out = state;

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised Fibonacci LFSR, the successor to the fixed 4-bit LFSR counter. Generalises width and feedback polynomial and adds:
- runtime seed load with protection against the all-zero lock-up state;
- a step counter;
- a wrap pulse marking completion of one full sequence period.

Used as a pseudo-random pattern source and as a compact counter in test and BIST logic. Single clock domain.

## Interface
- WIDTH, 8, register width in bits, legal range 3..32.
- TAPS, 8'hB8, feedback mask: bit i set means state[i] feeds the XOR; bit WIDTH-1 must be set.
- SEED, 1, reset and recovery value; must be non-zero.
- clk  input  1  clock, all state changes on rising edge.
- sync_rst  input  1  reset, synchronous and active-high.
- en  input  1  advance one step this cycle.
- load  input  1  load load_val as new state and new seed this cycle.
- load_val  input  WIDTH  value to load.
- cnt_out  output  WIDTH  current LFSR state (registered).
- step_cnt  output  WIDTH  steps taken since the last reset, load or wrap (registered).
- wrap  output  1  one-cycle pulse: the state has just returned to the active seed.
- lock_err  output  1  one-cycle pulse: a zero load was rejected.

## Operation
- Internal registers: state, seed_reg (the active seed), step_cnt, wrap, lock_err.
- Step function:
  - fb = XOR-reduce(state & TAPS);
  - next = {state[WIDTH-2:0], fb}, i.e. shift left with feedback into bit 0.
- Per-edge priority is sync_rst > load > en > hold.
- sync_rst = 1:
  - state = SEED, seed_reg = SEED;
  - step_cnt = 0, wrap = 0, lock_err = 0.
- load = 1 with load_val != 0:
  - state = load_val, seed_reg = load_val;
  - step_cnt = 0, wrap = 0, lock_err = 0;
  - en is ignored in that cycle.
- load = 1 with load_val == 0:
  - state = SEED, seed_reg = SEED, step_cnt = 0;
  - lock_err = 1 for that cycle only;
  - a zero state is never accepted.
- en = 1 (no load):
  - state = next.
  - If next == seed_reg: step_cnt = 0 and wrap = 1.
  - Otherwise: step_cnt = step_cnt + 1, wrapping modulo 2^WIDTH, and wrap = 0.
- en = 0 (no load):
  - state, seed_reg and step_cnt hold;
  - wrap = 0, lock_err = 0.
- Defensive recovery: if state is ever observed as 0 (for example after an upset), the next enabled step loads SEED instead of next, pulses lock_err, and clears step_cnt.
- With a maximal-length TAPS, wrap fires every 2^WIDTH − 1 enabled steps. Non-maximal polynomials wrap at their own period, or never if seed_reg lies off the cycle. This is legal, and step_cnt then simply rolls over.

## Timing
- All outputs are registered, with 1-cycle latency from the en/load edge to the updated cnt_out and step_cnt.
- wrap and lock_err are asserted in the same cycle that cnt_out shows the wrapped or recovered state, and are deasserted on the following edge unless re-triggered.
- Back-to-back en steps once per cycle; there is no throughput restriction.
- Asserting sync_rst mid-sequence returns to SEED on that edge; the in-flight step is discarded.
- load and en together: the load wins and no step occurs.
- load on the same cycle that would have wrapped: the load wins and wrap stays 0.

## Structure
- Shared package lfsr_pkg holds:
  - lfsr_step(state, taps) as a pure function;
  - default maximal tap constants: TAPS_4 = 4'hC, TAPS_8 = 8'hB8, TAPS_16 = 16'hB400, TAPS_32 = 32'h80200003.
- One sub-module, lfsr_fb, holding the combinational feedback and next-state logic, parametrised by WIDTH and TAPS. The top level holds registers, control priority and the counter.
- Elaboration checks: TAPS[WIDTH-1] == 1 and SEED != 0.

## Test plan
1. **Reset and first steps.** WIDTH=4, TAPS=4'hC, SEED=1; pulse sync_rst, then en=1 for 3 cycles -> cnt_out 0001 after reset, then 0010, 0100, 1001; step_cnt = 3.
2. **Full period and wrap.** Same configuration, en held for 15 steps -> the sequence passes through 0011, 0110, 1101, 1010, 0101, 1011, 0111, 1111, 1110, 1100, 1000, then 0001. wrap = 1 only on the 15th step, step_cnt returns to 0, and no value repeats before that.
3. **Seed load and wrap on new seed.** load=1, load_val=4'b1010 -> cnt_out = 1010 next cycle. A further 15 en steps return to 1010 with wrap = 1; wrap does not fire at 0001.
4. **Zero-load rejection.** load=1, load_val=0 -> cnt_out = 0001, lock_err = 1 for exactly one cycle, step_cnt = 0.
5. **Priority and hold.** load=1 and en=1 with load_val=0110 -> cnt_out = 0110 with no step. en=0 for 5 cycles -> cnt_out and step_cnt unchanged, wrap = 0. sync_rst asserted together with load=1 -> cnt_out = 0001.
6. **Wide configuration.** WIDTH=8, TAPS=8'hB8, SEED=1, en held for 255 steps -> exactly one wrap pulse, on step 255, with all 255 non-zero states visited.
